// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared CORDIC definitions for rotation-mode and vectoring-mode blocks.
//   - ITER_DEFAULT : default number of micro-rotations
//   - DEG90_Q / DEG180_Q : quadrant boundaries in Q12.20 degrees
//   - cordicState_t : FSM state encoding for the iterative engines
//   - atanLookup() : atan(2^-i) in Q12.20 degrees, i = 0..15
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int ITER_DEFAULT = 16;

    // Angles are signed degrees with 20 fractional bits.
    localparam logic [31:0] DEG90_Q  = 32'h05A0_0000;
    localparam logic [31:0] DEG180_Q = 32'h0B40_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } cordicState_t;

    // Arctangent of 2^-idx, expressed in Q12.20 degrees.
    function automatic logic [31:0] atanLookup(input logic [3:0] idx);
        logic [31:0] value;
        case (idx)
            4'd0:    value = 32'h02D0_0000;
            4'd1:    value = 32'h01A9_0A30;
            4'd2:    value = 32'h00E0_9470;
            4'd3:    value = 32'h0072_000A;
            4'd4:    value = 32'h0039_38AA;
            4'd5:    value = 32'h001C_A379;
            4'd6:    value = 32'h000E_52A1;
            4'd7:    value = 32'h0007_296D;
            4'd8:    value = 32'h0003_94BA;
            4'd9:    value = 32'h0001_CA5D;
            4'd10:   value = 32'h0000_E52E;
            4'd11:   value = 32'h0000_7297;
            4'd12:   value = 32'h0000_394B;
            4'd13:   value = 32'h0000_1CA5;
            4'd14:   value = 32'h0000_0E52;
            default: value = 32'h0000_0729;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// -----------------------------------------------------------------------------
// cordic_atan_lut
// Combinational arctangent table for the CORDIC micro-rotation step.
// Ports:
//   i_idx  [3:0] : iteration index i
//   o_atan [M:0] : atan(2^-i) in Q12.20 degrees (always positive)
// -----------------------------------------------------------------------------
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int M = 31
) (
    input  logic [3:0] i_idx,
    output logic [M:0] o_atan
);

    // Table values are positive, so resizing to the angle width is lossless
    // for any width that can hold the Q12.20 format.
    assign o_atan = (M+1)'(atanLookup(i_idx));

endmodule

// File: rtl/cordic_rotation_iter.sv
// -----------------------------------------------------------------------------
// cordic_rotation_iter
// Iterative rotation-mode CORDIC: rotates (x0, y0) by angle_in using one
// micro-rotation per clock on a single x/y/z datapath, then applies a
// shift-add gain compensation (~0.6074) before presenting the result.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous reset, active low
//   in_valid   : request valid (x0, y0, angle_in)
//   in_ready   : engine idle and able to accept a request
//   x0, y0     : input vector, signed N+1 bits
//   angle_in   : rotation angle, signed Q12.20 degrees, -180..+180
//   out_valid  : result valid (xf, yf, angle_res)
//   out_ready  : downstream accepts the result
//   xf, yf     : rotated, gain-compensated vector
//   angle_res  : residual angle after the final micro-rotation
// ITER must lie in 1..16 (the atan table and iteration counter are 4 bits).
// -----------------------------------------------------------------------------
module cordic_rotation_iter
    import cordic_pkg::*;
#(
    parameter int N    = 31,
    parameter int M    = 31,
    parameter int ITER = ITER_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N:0]   x0,
    input  logic signed [N:0]   y0,
    input  logic signed [M:0]   angle_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N:0]   xf,
    output logic signed [N:0]   yf,
    output logic signed [M:0]   angle_res
);

    localparam logic [3:0]        LAST_ITER = 4'(ITER - 1);
    localparam logic signed [M:0] POS_90    = (M+1)'(DEG90_Q);
    localparam logic signed [M:0] NEG_90    = -POS_90;

    cordicState_t       r_state;
    cordicState_t       w_nextState;

    logic signed [N:0]  r_x;
    logic signed [N:0]  r_y;
    logic signed [M:0]  r_z;
    logic [3:0]         r_iter;
    logic signed [N:0]  r_xf;
    logic signed [N:0]  r_yf;
    logic signed [M:0]  r_angleRes;

    logic signed [N:0]  w_preX;
    logic signed [N:0]  w_preY;
    logic signed [M:0]  w_preZ;
    logic [M:0]         w_atan;
    logic signed [N:0]  w_xShift;
    logic signed [N:0]  w_yShift;
    logic signed [N:0]  w_xNext;
    logic signed [N:0]  w_yNext;
    logic signed [M:0]  w_zNext;
    logic signed [N:0]  w_xScaled;
    logic signed [N:0]  w_yScaled;

    cordic_atan_lut #(
        .M      (M)
    ) u_atanLut (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: accept only in IDLE, run ITER micro-rotations,
    // one scaling cycle, then hold the result until downstream takes it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)              w_nextState = BUSY;
            BUSY:    if (r_iter == LAST_ITER)   w_nextState = SCALE;
            SCALE:                              w_nextState = DONE;
            DONE:    if (out_ready)             w_nextState = IDLE;
            default:                            w_nextState = IDLE;
        endcase
    end

    // Handshake outputs depend on state alone.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Quadrant pre-rotation by +/-90 degrees brings the remaining angle into
    // the +/-90 degree convergence range of the micro-rotation sequence.
    always_comb begin
        w_preX = x0;
        w_preY = y0;
        w_preZ = angle_in;
        if (angle_in > POS_90) begin
            w_preX = -y0;
            w_preY = x0;
            w_preZ = angle_in - POS_90;
        end else if (angle_in < NEG_90) begin
            w_preX = y0;
            w_preY = -x0;
            w_preZ = angle_in + POS_90;
        end
    end

    // One micro-rotation: the sign of z picks the rotation direction.
    always_comb begin
        w_xShift = r_x >>> r_iter;
        w_yShift = r_y >>> r_iter;
        if (!r_z[M]) begin
            w_xNext = r_x - w_yShift;
            w_yNext = r_y + w_xShift;
            w_zNext = r_z - $signed(w_atan);
        end else begin
            w_xNext = r_x + w_yShift;
            w_yNext = r_y - w_xShift;
            w_zNext = r_z + $signed(w_atan);
        end
    end

    // Gain compensation 1/2 + 1/8 + 1/64 - 1/32 - 1/512 ~ 0.6074 ~ 1/K.
    always_comb begin
        w_xScaled = (r_x >>> 1) + (r_x >>> 3) + (r_x >>> 6) - (r_x >>> 5) - (r_x >>> 9);
        w_yScaled = (r_y >>> 1) + (r_y >>> 3) + (r_y >>> 6) - (r_y >>> 5) - (r_y >>> 9);
    end

    // Datapath registers; result registers only move when leaving SCALE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_iter     <= '0;
            r_xf       <= '0;
            r_yf       <= '0;
            r_angleRes <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x    <= w_preX;
                        r_y    <= w_preY;
                        r_z    <= w_preZ;
                        r_iter <= '0;
                    end
                end
                BUSY: begin
                    r_x    <= w_xNext;
                    r_y    <= w_yNext;
                    r_z    <= w_zNext;
                    r_iter <= r_iter + 4'd1;
                end
                SCALE: begin
                    r_xf       <= w_xScaled;
                    r_yf       <= w_yScaled;
                    r_angleRes <= r_z;
                end
                default: begin
                end
            endcase
        end
    end

    assign xf        = r_xf;
    assign yf        = r_yf;
    assign angle_res = r_angleRes;

endmodule
